// File: rtl/luffa_round_ctrl.sv
// rtl/luffa_round_ctrl.sv - Luffa-256 round sequencer: message injection, Q_j steps, blank finalization.
// Optional LUFFA_CTRL_BLKCNT_EN adds blk_cnt, a saturating count of accepted blocks.
module luffa_round_ctrl #(
  parameter int STEPS        = 8,
  parameter int STEP_W       = 3,
  parameter int BLANK_ROUNDS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic              msg_valid,
  input  logic              msg_last,
  output logic              msg_ready,
  output logic              msg_load,
  output logic              state_init,
  output logic              mi_en,
  output logic              zero_msg,
  output logic              const_load,
  output logic              step_en,
  output logic [STEP_W-1:0] step_cnt,
  output logic              busy,
  output logic              digest_valid,
`ifdef LUFFA_CTRL_BLKCNT_EN
  output logic [31:0]       blk_cnt,
`endif
  input  logic              digest_ack
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_INJ   = 3'd2,
    S_PERM  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  state_t            state_q;
  logic [STEP_W-1:0] step_cnt_q;
  logic              last_q;
  logic [1:0]        blank_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      step_cnt_q <= '0;
      last_q     <= 1'b0;
      blank_q    <= 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (init) state_q <= S_READY;
        end
        S_READY: begin
          if (!init && msg_valid) begin
            last_q  <= msg_last;
            state_q <= S_INJ;
          end
        end
        S_INJ: begin
          step_cnt_q <= '0;
          state_q    <= S_PERM;
        end
        S_PERM: begin
          if (step_cnt_q == LAST_STEP) begin
            step_cnt_q <= '0;
            if (!last_q) begin
              state_q <= S_READY;
            end else if (int'(blank_q) < BLANK_ROUNDS) begin
              blank_q <= blank_q + 2'd1;
              state_q <= S_INJ;
            end else begin
              state_q <= S_DONE;
            end
          end else begin
            step_cnt_q <= step_cnt_q + STEP_W'(1);
          end
        end
        S_DONE: begin
          // init here doubles as the acknowledge and restarts straight into READY
          if (init || digest_ack) begin
            last_q  <= 1'b0;
            blank_q <= 2'd0;
            state_q <= init ? S_READY : S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign state_init   = init && (state_q == S_IDLE || state_q == S_READY || state_q == S_DONE);
  assign msg_ready    = (state_q == S_READY) && !init;
  assign msg_load     = msg_ready && msg_valid;
  assign mi_en        = (state_q == S_INJ);
  assign const_load   = (state_q == S_INJ);
  assign zero_msg     = (state_q == S_INJ) && (blank_q != 2'd0);
  assign step_en      = (state_q == S_PERM);
  assign busy         = (state_q == S_INJ) || (state_q == S_PERM);
  assign digest_valid = (state_q == S_DONE);
  assign step_cnt     = step_cnt_q;

`ifdef LUFFA_CTRL_BLKCNT_EN
  logic [31:0] blk_cnt_q;
  logic [31:0] blk_cnt_d;

  always_comb begin
    blk_cnt_d = blk_cnt_q;
    if (state_init)
      blk_cnt_d = 32'd0;
    else if (msg_load && blk_cnt_q != 32'hFFFF_FFFF)
      blk_cnt_d = blk_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blk_cnt_q <= 32'd0;
    else        blk_cnt_q <= blk_cnt_d;
  end

  assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_luffa_round_ctrl.sv
// tb/tb_luffa_round_ctrl.sv - directed bench for luffa_round_ctrl (BLANK_ROUNDS=1 and =0 instances).
module tb_luffa_round_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init = 1'b0;
  logic msg_valid = 1'b0;
  logic msg_last = 1'b0;
  logic digest_ack = 1'b0;

  logic       msg_ready_a, msg_load_a, state_init_a, mi_en_a, zero_msg_a, const_load_a;
  logic       step_en_a, busy_a, digest_valid_a;
  logic [2:0] step_cnt_a;
  logic       msg_ready_b, msg_load_b, state_init_b, mi_en_b, zero_msg_b, const_load_b;
  logic       step_en_b, busy_b, digest_valid_b;
  logic [2:0] step_cnt_b;
`ifdef LUFFA_CTRL_BLKCNT_EN
  logic [31:0] blk_cnt_a, blk_cnt_b;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  luffa_round_ctrl #(.STEPS(8), .STEP_W(3), .BLANK_ROUNDS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .init(init), .msg_valid(msg_valid), .msg_last(msg_last),
    .msg_ready(msg_ready_a), .msg_load(msg_load_a), .state_init(state_init_a),
    .mi_en(mi_en_a), .zero_msg(zero_msg_a), .const_load(const_load_a),
    .step_en(step_en_a), .step_cnt(step_cnt_a), .busy(busy_a),
    .digest_valid(digest_valid_a),
`ifdef LUFFA_CTRL_BLKCNT_EN
    .blk_cnt(blk_cnt_a),
`endif
    .digest_ack(digest_ack)
  );

  luffa_round_ctrl #(.STEPS(8), .STEP_W(3), .BLANK_ROUNDS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .init(init), .msg_valid(msg_valid), .msg_last(msg_last),
    .msg_ready(msg_ready_b), .msg_load(msg_load_b), .state_init(state_init_b),
    .mi_en(mi_en_b), .zero_msg(zero_msg_b), .const_load(const_load_b),
    .step_en(step_en_b), .step_cnt(step_cnt_b), .busy(busy_b),
    .digest_valid(digest_valid_b),
`ifdef LUFFA_CTRL_BLKCNT_EN
    .blk_cnt(blk_cnt_b),
`endif
    .digest_ack(digest_ack)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hand timing: cycle k after a last-block accept at k=0, STEPS=8.
  function automatic logic [31:0] exp_vec(input int k, input int br);
    logic mi, z, se, dv;
    logic [2:0] sc;
    mi = (k == 1) || (br == 1 && k == 10);
    z  = (br == 1 && k == 10);
    se = (k >= 2 && k <= 9) || (br == 1 && k >= 11 && k <= 18);
    dv = (br == 1) ? (k >= 19) : (k >= 10);
    sc = !se ? 3'd0 : (k <= 9 ? 3'(k - 2) : 3'(k - 11));
    return {22'b0, mi, z, mi, se, mi | se, dv, 1'b0, sc};
  endfunction

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy_a}, 0);
    chk("rst_step_en", {31'b0, step_en_a}, 0);
    chk("rst_step_cnt", {29'b0, step_cnt_a}, 0);
    chk("rst_dv", {31'b0, digest_valid_a}, 0);
    chk("rst_ready", {31'b0, msg_ready_a}, 0);
`ifdef LUFFA_CTRL_BLKCNT_EN
    chk("rst_blk_cnt", blk_cnt_a, 0);
`endif
    rst_n = 1'b1;

    // single last block, finalization
    init = 1'b1;
    #1;
    chk("t1_init_a", {31'b0, state_init_a}, 1);
    chk("t1_init_b", {31'b0, state_init_b}, 1);
    chk("t1_init_ready", {31'b0, msg_ready_a}, 0);
    step();
    init = 1'b0; msg_valid = 1'b1; msg_last = 1'b1;
    #1;
    chk("t1_load_a", {31'b0, msg_load_a}, 1);
    chk("t1_load_b", {31'b0, msg_load_b}, 1);
    for (int k = 1; k <= 20; k++) begin
      step();
      msg_valid = 1'b0; msg_last = 1'b0;
      digest_ack = (k == 20);
      #1;
      chk($sformatf("t1_a_k%0d", k),
          {22'b0, mi_en_a, zero_msg_a, const_load_a, step_en_a, busy_a, digest_valid_a, msg_ready_a, step_cnt_a},
          exp_vec(k, 1));
      chk($sformatf("t1_b_k%0d", k),
          {22'b0, mi_en_b, zero_msg_b, const_load_b, step_en_b, busy_b, digest_valid_b, msg_ready_b, step_cnt_b},
          exp_vec(k, 0));
    end
    step();
    digest_ack = 1'b0;
    #1;
    chk("t1_ack_dv_a", {31'b0, digest_valid_a}, 0);
    chk("t1_ack_dv_b", {31'b0, digest_valid_b}, 0);
    chk("t1_idle_ready", {31'b0, msg_ready_a}, 0);

    // three blocks back-to-back, last on the third
    init = 1'b1;
    #1;
    chk("t2_init", {31'b0, state_init_a}, 1);
    step();
    init = 1'b0;
    for (int k = 0; k <= 39; k++) begin
      msg_valid = (k <= 20);
      msg_last  = (k >= 20);
      #1;
      chk($sformatf("t2_load_k%0d", k), {31'b0, msg_load_a}, (k == 0 || k == 10 || k == 20) ? 1 : 0);
      if (k == 38) chk("t2_dv_early", {31'b0, digest_valid_a}, 0);
      if (k == 39) chk("t2_dv", {31'b0, digest_valid_a}, 1);
      step();
    end
    msg_valid = 1'b0; msg_last = 1'b0;
    repeat (19) step();
    chk("t2_dv_held", {31'b0, digest_valid_a}, 1);
`ifdef LUFFA_CTRL_BLKCNT_EN
    chk("t2_blk_cnt3", blk_cnt_a, 3);
`endif
    init = 1'b1;
    #1;
    chk("t2_done_init", {31'b0, state_init_a}, 1);
    step();
    init = 1'b0;
    #1;
    chk("t2_restart_dv", {31'b0, digest_valid_a}, 0);
    chk("t2_restart_ready", {31'b0, msg_ready_a}, 1);
`ifdef LUFFA_CTRL_BLKCNT_EN
    chk("t2_blk_cnt0", blk_cnt_a, 0);
`endif

    // init ignored during PERM, honoured in READY
    msg_valid = 1'b1; msg_last = 1'b0;
    #1;
    chk("t3_load", {31'b0, msg_load_a}, 1);
    for (int k = 1; k <= 10; k++) begin
      step();
      msg_valid = 1'b0;
      init = (k == 6);
      #1;
      if (k >= 2 && k <= 9) chk($sformatf("t3_cnt_k%0d", k), {29'b0, step_cnt_a}, 32'(k - 2));
      if (k == 6) chk("t3_perm_init", {31'b0, state_init_a}, 0);
      if (k == 10) chk("t3_ready", {31'b0, msg_ready_a}, 1);
    end
    init = 1'b1;
    #1;
    chk("t3_ready_init", {31'b0, state_init_a}, 1);
    chk("t3_ready_forced0", {31'b0, msg_ready_a}, 0);
    step();
    init = 1'b0;

    // asynchronous reset mid-PERM
    msg_valid = 1'b1;
    #1;
    chk("t4_load", {31'b0, msg_load_a}, 1);
    for (int k = 1; k <= 7; k++) begin
      step();
      msg_valid = 1'b0;
    end
    chk("t4_cnt5", {29'b0, step_cnt_a}, 5);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_busy", {31'b0, busy_a}, 0);
    chk("t4_rst_step_en", {31'b0, step_en_a}, 0);
    chk("t4_rst_cnt", {29'b0, step_cnt_a}, 0);
    step();
    rst_n = 1'b1;
    msg_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("t4_noready_%0d", k), {31'b0, msg_ready_a}, 0);
      chk($sformatf("t4_noload_%0d", k), {31'b0, msg_load_a | mi_en_a | step_en_a}, 0);
      step();
    end
    msg_valid = 1'b0;
    init = 1'b1;
    #1;
    chk("t4_init", {31'b0, state_init_a}, 1);
    step();
    init = 1'b0;
    #1;
    chk("t4_ready", {31'b0, msg_ready_a}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
